// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 controller.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        WAIT_NEXT,
        CS_HOLD,
        CS_IDLE
    } spi_state_e;

    localparam logic       SPI_CPOL    = 1'b0;
    localparam logic       SPI_CPHA    = 1'b0;
    localparam logic [1:0] SPI_MODE0   = {SPI_CPOL, SPI_CPHA};
    localparam logic       CS_ACTIVE   = 1'b0;
    localparam logic       CS_INACTIVE = ~CS_ACTIVE;

endpackage

// File: rtl/spi_controller_clk_gen.sv
// Half-bit timer: produces the SPI clock and its rise/fall strobes.
// With i_toggle low it only times half-bit intervals (setup / CS hold).
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int unsigned CLKS_PER_HALF_BIT = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_run,
    input  logic i_toggle,
    output logic o_sclk,
    output logic o_half_done_c,
    output logic o_rise_c,
    output logic o_fall_c
);

    localparam int unsigned      CNT_W     = $clog2(CLKS_PER_HALF_BIT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_HALF_BIT - 1);
    localparam logic             SCLK_IDLE = SPI_MODE0[1];

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sclk_q, sclk_d;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q  <= '0;
            sclk_q <= SCLK_IDLE;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    always_comb begin
        cnt_d         = '0;
        sclk_d        = SCLK_IDLE;
        o_half_done_c = i_run && (cnt_q == CNT_LAST);
        o_rise_c      = o_half_done_c && i_toggle && (sclk_q == SCLK_IDLE);
        o_fall_c      = o_half_done_c && i_toggle && (sclk_q != SCLK_IDLE);
        if (i_run) begin
            cnt_d  = o_half_done_c ? '0 : cnt_q + CNT_W'(1);
            sclk_d = (o_rise_c || o_fall_c) ? ~sclk_q : sclk_q;
        end
    end

    assign o_sclk = sclk_q;

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 initiator: byte handshake in, framed MSB-first SPI out.
// Optional macro SPI_WAIT_TIMEOUT_EN closes an idle open frame after WAIT_TIMEOUT_CLKS.
module spi_controller
    import spi_pkg::*;
#(
    parameter int unsigned CLKS_PER_HALF_BIT = 4,
    parameter int unsigned CS_IDLE_CLKS      = 8,
    parameter int unsigned WAIT_TIMEOUT_CLKS = 256
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_tx_dv,
    input  logic [7:0] i_tx_byte,
    input  logic       i_tx_last,
    output logic       o_tx_ready,
    output logic       o_rx_dv,
    output logic [7:0] o_rx_byte,
    output logic       o_busy,
    output logic       o_spi_clk,
    output logic       o_spi_cs_n,
    output logic       o_spi_copi,
    input  logic       i_spi_cipo
);

    localparam int unsigned           IDLE_CNT_W = $clog2(CS_IDLE_CLKS) + 1;
    localparam logic [IDLE_CNT_W-1:0] IDLE_LAST  = IDLE_CNT_W'(CS_IDLE_CLKS - 1);

    spi_state_e      state_q, state_d;
    logic [7:0]      tx_sr_q, tx_sr_d;
    logic [7:0]      rx_sr_q, rx_sr_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic            last_q, last_d;
    logic [IDLE_CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic            cs_n_q, cs_n_d;
    logic            copi_q, copi_d;
    logic            rx_dv_q, rx_dv_d;
    logic [7:0]      rx_byte_q, rx_byte_d;
    logic            tx_ready_q, tx_ready_d;
    logic            busy_q, busy_d;

    logic accept_c;
    logic clk_run_c, clk_toggle_c;
    logic half_done_c, rise_c, fall_c;
    logic sclk;

    assign accept_c     = i_tx_dv && tx_ready_q;
    assign clk_run_c    = (state_q == SETUP) || (state_q == XFER) || (state_q == CS_HOLD);
    assign clk_toggle_c = (state_q == XFER);

    spi_clk_gen #(
        .CLKS_PER_HALF_BIT(CLKS_PER_HALF_BIT)
    ) u_clk_gen (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_run        (clk_run_c),
        .i_toggle     (clk_toggle_c),
        .o_sclk       (sclk),
        .o_half_done_c(half_done_c),
        .o_rise_c     (rise_c),
        .o_fall_c     (fall_c)
    );

`ifdef SPI_WAIT_TIMEOUT_EN
    localparam int unsigned           WAIT_CNT_W = $clog2(WAIT_TIMEOUT_CLKS) + 1;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST  = WAIT_CNT_W'(WAIT_TIMEOUT_CLKS - 1);

    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic                  wait_expired_c;

    // Counts only while parked in WAIT_NEXT; any accept restarts it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        wait_cnt_d     = '0;
        wait_expired_c = 1'b0;
        if (state_q == WAIT_NEXT && !accept_c) begin
            wait_cnt_d     = wait_cnt_q + WAIT_CNT_W'(1);
            wait_expired_c = (wait_cnt_q == WAIT_LAST);
        end
    end
`else
    logic wait_expired_c;
    logic unused_wait_timeout;

    assign wait_expired_c      = 1'b0;
    assign unused_wait_timeout = (WAIT_TIMEOUT_CLKS != 0);
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= IDLE;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            bit_cnt_q  <= '0;
            last_q     <= 1'b0;
            idle_cnt_q <= '0;
            cs_n_q     <= CS_INACTIVE;
            copi_q     <= 1'b0;
            rx_dv_q    <= 1'b0;
            rx_byte_q  <= '0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            bit_cnt_q  <= bit_cnt_d;
            last_q     <= last_d;
            idle_cnt_q <= idle_cnt_d;
            cs_n_q     <= cs_n_d;
            copi_q     <= copi_d;
            rx_dv_q    <= rx_dv_d;
            rx_byte_q  <= rx_byte_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        bit_cnt_d  = bit_cnt_q;
        last_d     = last_q;
        idle_cnt_d = '0;
        cs_n_d     = cs_n_q;
        copi_d     = copi_q;
        rx_dv_d    = 1'b0;
        rx_byte_d  = rx_byte_q;

        unique case (state_q)
            IDLE: begin
                cs_n_d = CS_INACTIVE;
                if (accept_c) begin
                    tx_sr_d = i_tx_byte;
                    last_d  = i_tx_last;
                    copi_d  = i_tx_byte[7];
                    cs_n_d  = CS_ACTIVE;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (half_done_c) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                if (rise_c) begin
                    rx_sr_d = {rx_sr_q[6:0], i_spi_cipo};
                end
                // Each falling edge advances COPI; the eighth one closes the byte.
                if (fall_c) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    tx_sr_d   = {tx_sr_q[6:0], 1'b0};
                    copi_d    = tx_sr_q[6];
                    if (bit_cnt_q == 3'd7) begin
                        rx_dv_d   = 1'b1;
                        rx_byte_d = rx_sr_q;
                        state_d   = last_q ? CS_HOLD : WAIT_NEXT;
                    end
                end
            end
            WAIT_NEXT: begin
                if (accept_c) begin
                    tx_sr_d = i_tx_byte;
                    last_d  = i_tx_last;
                    copi_d  = i_tx_byte[7];
                    state_d = SETUP;
                end else if (wait_expired_c) begin
                    state_d = CS_HOLD;
                end
            end
            CS_HOLD: begin
                if (half_done_c) begin
                    cs_n_d  = CS_INACTIVE;
                    state_d = CS_IDLE;
                end
            end
            CS_IDLE: begin
                idle_cnt_d = idle_cnt_q + IDLE_CNT_W'(1);
                if (idle_cnt_q == IDLE_LAST) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cs_n_d  = CS_INACTIVE;
                state_d = IDLE;
            end
        endcase

        tx_ready_d = (state_d == IDLE) || (state_d == WAIT_NEXT);
        busy_d     = (state_d != IDLE);
    end

    assign o_tx_ready = tx_ready_q;
    assign o_rx_dv    = rx_dv_q;
    assign o_rx_byte  = rx_byte_q;
    assign o_busy     = busy_q;
    assign o_spi_clk  = sclk;
    assign o_spi_cs_n = cs_n_q;
    assign o_spi_copi = copi_q;

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller (CLKS_PER_HALF_BIT=2, CS_IDLE_CLKS=8, WAIT_TIMEOUT_CLKS=16).
`timescale 1ns/1ps
module tb_spi_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       tx_last;
    logic       tx_ready;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       busy;
    logic       sclk;
    logic       cs_n;
    logic       copi;
    logic       cipo;

    logic [1:0] cipo_mode = 2'd1;
    logic [7:0] model_byte = 8'h00;
    logic [7:0] model_sr = 8'h00;
    logic       sclk_prev = 1'b0;

    int         vectors = 0;
    int         miscompares = 0;

    int         rise_n = 0;
    logic [7:0] copi_sr = 8'h00;
    int         cs_rise_n = 0;
    logic [7:0] rx_log [0:63];
    int         rx_n = 0;
    int         hi_run = 0;
    int         last_gap = 0;
    logic       x_seen = 1'b0;

    always #5 clk = ~clk;

    spi_controller #(
        .CLKS_PER_HALF_BIT(2),
        .CS_IDLE_CLKS     (8),
        .WAIT_TIMEOUT_CLKS(16)
    ) dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_tx_dv   (tx_dv),
        .i_tx_byte (tx_byte),
        .i_tx_last (tx_last),
        .o_tx_ready(tx_ready),
        .o_rx_dv   (rx_dv),
        .o_rx_byte (rx_byte),
        .o_busy    (busy),
        .o_spi_clk (sclk),
        .o_spi_cs_n(cs_n),
        .o_spi_copi(copi),
        .i_spi_cipo(cipo)
    );

    // Peripheral side: shift register model, loopback, or undriven.
    assign cipo = (cipo_mode == 2'd0) ? model_sr[7] :
                  (cipo_mode == 2'd1) ? copi : 1'bx;

    always @(negedge clk) begin
        if (cs_n) model_sr <= model_byte;
        else if (sclk_prev && !sclk) model_sr <= {model_sr[6:0], 1'b0};
        sclk_prev <= sclk;
    end

    always @(posedge sclk) begin
        rise_n  = rise_n + 1;
        copi_sr = {copi_sr[6:0], copi};
    end

    always @(posedge cs_n) cs_rise_n = cs_rise_n + 1;

    always @(negedge clk) begin
        if (rx_dv === 1'b1) begin
            rx_log[rx_n % 64] <= rx_byte;
            rx_n <= rx_n + 1;
        end
        if (rst === 1'b0 && $isunknown(rx_dv)) x_seen <= 1'b1;
        if (cs_n === 1'b1) begin
            hi_run <= hi_run + 1;
        end else begin
            if (hi_run != 0) last_gap <= hi_run;
            hi_run <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic l);
        int t = 0;
        while (tx_ready !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("send_ready", 32'(tx_ready), 32'd1);
        tx_dv   = 1'b1;
        tx_byte = b;
        tx_last = l;
        @(negedge clk);
        tx_dv   = 1'b0;
    endtask

    task automatic wait_rx();
        int t = 0;
        while (rx_dv !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("rx_dv_seen", 32'(rx_dv), 32'd1);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!(tx_ready === 1'b1 && busy === 1'b0) && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("idle_reached", 32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rb;
        int r0;
        int c0;
        int t;
        int low;

        rst     = 1'b1;
        tx_dv   = 1'b0;
        tx_byte = 8'h00;
        tx_last = 1'b0;
        tick(3);

        check("rst_cs_n",     32'(cs_n),     32'd1);
        check("rst_sclk",     32'(sclk),     32'd0);
        check("rst_copi",     32'(copi),     32'd0);
        check("rst_rx_dv",    32'(rx_dv),    32'd0);
        check("rst_rx_byte",  32'(rx_byte),  32'h00);
        check("rst_tx_ready", 32'(tx_ready), 32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        rst = 1'b0;
        tick(1);
        check("tx_ready_after_reset", 32'(tx_ready), 32'd1);

        // Single byte 0xA5, peripheral returns 0x3C; exact frame timing.
        cipo_mode  = 2'd0;
        model_byte = 8'h3C;
        r0 = rise_n;
        send(8'hA5, 1'b1);
        check("t1_cs_low",     32'(cs_n),     32'd0);
        check("t1_ready_drop", 32'(tx_ready), 32'd0);
        check("t1_busy",       32'(busy),     32'd1);
        check("t1_copi_bit7",  32'(copi),     32'd1);
        tick(33);
        check("t1_rx_dv_c33",  32'(rx_dv),    32'd0);
        tick(1);
        check("t1_rx_dv_c34",  32'(rx_dv),    32'd1);
        check("t1_rx_byte",    32'(rx_byte),  32'h3C);
        tick(1);
        check("t1_cs_c35",     32'(cs_n),     32'd0);
        check("t1_rx_dv_pulse",32'(rx_dv),    32'd0);
        tick(1);
        check("t1_cs_c36",     32'(cs_n),     32'd1);
        tick(7);
        check("t1_ready_c43",  32'(tx_ready), 32'd0);
        tick(1);
        check("t1_ready_c44",  32'(tx_ready), 32'd1);
        check("t1_busy_c44",   32'(busy),     32'd0);
        check("t1_copi_seq",   32'(copi_sr),  32'hA5);
        check("t1_rises",      32'(rise_n - r0), 32'd8);

        // Three-byte frame in loopback; CS held low throughout.
        cipo_mode = 2'd1;
        rb = rx_n;
        r0 = rise_n;
        c0 = cs_rise_n;
        send(8'h01, 1'b0);
        wait_rx();
        send(8'h02, 1'b0);
        wait_rx();
        send(8'h03, 1'b1);
        wait_rx();
        check("t2_cs_low_thru", 32'(cs_rise_n - c0), 32'd0);
        wait_idle();
        check("t2_rx0",      32'(rx_log[rb % 64]),       32'h01);
        check("t2_rx1",      32'(rx_log[(rb + 1) % 64]), 32'h02);
        check("t2_rx2",      32'(rx_log[(rb + 2) % 64]), 32'h03);
        check("t2_rises",    32'(rise_n - r0),    32'd24);
        check("t2_cs_close", 32'(cs_rise_n - c0), 32'd1);

        // i_tx_dv held high with 0xFF mid-transfer is ignored.
        rb = rx_n;
        r0 = rise_n;
        send(8'h96, 1'b1);
        tx_dv   = 1'b1;
        tx_byte = 8'hFF;
        tx_last = 1'b1;
        tick(30);
        check("t3_ready_low", 32'(tx_ready), 32'd0);
        tx_dv = 1'b0;
        wait_rx();
        check("t3_rx_byte", 32'(rx_byte), 32'h96);
        wait_idle();
        check("t3_rx_count", 32'(rx_n - rb),   32'd1);
        check("t3_copi_seq", 32'(copi_sr),     32'h96);
        check("t3_rises",    32'(rise_n - r0), 32'd8);

        // Reset after the 4th rising edge, then a clean 0x55 frame.
        rb = rx_n;
        r0 = rise_n;
        send(8'hC3, 1'b1);
        t = 0;
        while ((rise_n - r0) < 4 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("t4_rise4_reached", 32'(rise_n - r0), 32'd4);
        rst = 1'b1;
        tick(1);
        check("t4_cs_n",  32'(cs_n),  32'd1);
        check("t4_sclk",  32'(sclk),  32'd0);
        check("t4_rx_dv", 32'(rx_dv), 32'd0);
        check("t4_busy",  32'(busy),  32'd0);
        rst = 1'b0;
        tick(2);
        check("t4_ready",    32'(tx_ready),  32'd1);
        check("t4_no_rx_dv", 32'(rx_n - rb), 32'd0);
        r0 = rise_n;
        send(8'h55, 1'b1);
        wait_rx();
        check("t4_rx_byte", 32'(rx_byte), 32'h55);
        wait_idle();
        check("t4_copi_seq", 32'(copi_sr),     32'h55);
        check("t4_rises",    32'(rise_n - r0), 32'd8);

        // Open frame (last=0) with no follow-up byte.
        send(8'h5A, 1'b0);
        wait_rx();
        check("t5_rx_byte", 32'(rx_byte), 32'h5A);
`ifdef SPI_WAIT_TIMEOUT_EN
        tick(17);
        check("t5_cs_c17", 32'(cs_n), 32'd0);
        tick(1);
        check("t5_cs_c18", 32'(cs_n), 32'd1);
        wait_idle();
`else
        low = 0;
        repeat (1000) begin
            @(negedge clk);
            if (cs_n === 1'b0) low++;
        end
        check("t5_cs_held", 32'(low), 32'd1000);
        check("t5_ready_waiting", 32'(tx_ready), 32'd1);
        send(8'h00, 1'b1);
        wait_rx();
        check("t5_close_rx", 32'(rx_byte), 32'h00);
        wait_idle();
`endif

        // Back-to-back frames with CIPO undriven.
        cipo_mode = 2'd2;
        rb = rx_n;
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        wait_rx();
        check("t6_cs_gap", 32'(last_gap), 32'd9);
        wait_idle();
        check("t6_rx_count", 32'(rx_n - rb), 32'd2);
        check("t6_rx_dv_no_x", 32'(x_seen), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_controller.md
Name: spi_controller

Overview:
SPI mode-0 controller (initiator) for the opposite end of the debugger's SPI peripheral link. Used in the FPGA-side bench harness and the on-board self-test path to drive the debugger command stream over the four-wire interface. Converts a byte-stream handshake into SPI frames: it generates the SPI clock and chip select, shifts COPI out MSB-first, and captures CIPO.

Parameters:
CLKS_PER_HALF_BIT, 4, i_clk cycles per SPI clock half-period; legal values are 2 or more.
CS_IDLE_CLKS, 8, minimum i_clk cycles with cs_n high between frames; legal values are 1 or more.
WAIT_TIMEOUT_CLKS, 256, cycles in WAIT_NEXT before forced CS release; used only with the optional feature.

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_tx_dv  in  1  byte valid; accepted when i_tx_dv && o_tx_ready
i_tx_byte  in  8  byte to transmit
i_tx_last  in  1  qualifies i_tx_dv; this byte ends the frame
o_tx_ready  out  1  controller can accept a byte
o_rx_dv  out  1  one-cycle pulse; o_rx_byte is valid
o_rx_byte  out  8  byte captured from CIPO
o_busy  out  1  high whenever state is not IDLE
o_spi_clk  out  1  SPI clock (CPOL=0)
o_spi_cs_n  out  1  chip select, active low
o_spi_copi  out  1  controller-out data
i_spi_cipo  in  1  peripheral-out data; high-z is tolerated because the sampled value is simply stored

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high; every output is registered.
- Reset values: o_spi_cs_n=1, o_spi_clk=0, o_spi_copi=0, o_rx_dv=0, o_rx_byte=0x00, o_tx_ready=0, o_busy=0. o_tx_ready rises on the first cycle after reset deasserts.
- Reset mid-frame: on the next edge, cs_n=1 and sclk=0, and the partial rx byte is discarded (no o_rx_dv).
- Mode 0, MSB first. COPI changes only while sclk is low. CIPO is sampled on the internal cycle that drives the sclk rising edge.
- Handshake: a byte is accepted only in IDLE or WAIT_NEXT. i_tx_byte and i_tx_last are latched on acceptance. o_tx_ready drops the cycle after acceptance.
- States:
  - IDLE: tx_ready=1, cs_n=1. On accept: cs_n goes low, copi=bit7, go to SETUP.
  - SETUP: hold for CLKS_PER_HALF_BIT cycles, then go to XFER.
  - XFER: 8 bit periods of 2*CLKS_PER_HALF_BIT cycles each.
    - sclk rises: sample CIPO into the shift register.
    - sclk falls: shift the next COPI bit out.
    - After the 8th falling edge: pulse o_rx_dv with the full byte. Then go to CS_HOLD if last was set, otherwise to WAIT_NEXT.
  - WAIT_NEXT: cs_n stays low, sclk=0, tx_ready=1. On accept: copi=bit7, go to SETUP, so a half-bit gap precedes the next rising edge.
  - CS_HOLD: hold cs_n low for CLKS_PER_HALF_BIT cycles, then set cs_n=1 and go to CS_IDLE.
  - CS_IDLE: count CS_IDLE_CLKS cycles, then go to IDLE.
- Frame timing: from acceptance to o_rx_dv is CLKS_PER_HALF_BIT*17 cycles (setup plus 16 half-bits).
- o_rx_dv and acceptance of the next byte may fall on the same cycle. The byte is accepted only when o_tx_ready is already 1.
- i_tx_dv in any other state is ignored; the controller holds no buffering.
- Counters: half-bit counter width is $clog2(CLKS_PER_HALF_BIT)+1. Bit counter is 3 bits and wraps 7 to 0 at end of byte.

Optional Feature:
SPI_WAIT_TIMEOUT_EN
- Defined: in WAIT_NEXT, a counter increments each cycle and resets on acceptance. When it reaches WAIT_TIMEOUT_CLKS with no accept, go to CS_HOLD, then close the frame normally.
- Undefined: WAIT_NEXT holds CS low indefinitely and no counter logic is generated.

Decomposition:
- Shared package spi_pkg:
  - state enum {IDLE, SETUP, XFER, WAIT_NEXT, CS_HOLD, CS_IDLE}
  - SPI_MODE0 constants (CPOL=0, CPHA=0)
  - CS_ACTIVE=1'b0
- Natural sub-module: spi_clk_gen. It holds the half-bit counter and emits rise/fall strobes plus sclk.

Test Plan:
- CLKS_PER_HALF_BIT=2, single byte 0xA5 with last=1, peripheral model returns 0x3C:
  - COPI sequence 1,0,1,0,0,1,0,1 on rising edges.
  - o_rx_byte=0x3C with o_rx_dv at cycle 34 after accept.
  - cs_n high 2 cycles later, o_tx_ready after a further 8 cycles.
- Three-byte frame 0x01,0x02,0x03 (last on the third byte) looped back through a peripheral model:
  - cs_n stays low through all three bytes.
  - rx returns 0x01,0x02,0x03.
  - Exactly 24 sclk rising edges.
- i_tx_dv held high during XFER with byte 0xFF: ignored; transmitted data unchanged; no extra o_rx_dv.
- Reset asserted after the 4th rising edge: next cycle cs_n=1, sclk=0, no o_rx_dv; after release, a clean 0x55 frame works.
- Build with SPI_WAIT_TIMEOUT_EN, WAIT_TIMEOUT_CLKS=16, byte with last=0 and no follow-up:
  - cs_n releases 16+2 cycles after o_rx_dv.
  - Without the macro, cs_n remains low for 1000 cycles.
- Back-to-back frames: cs_n is high for at least CS_IDLE_CLKS cycles between them; CIPO tied to high-z/X produces no X on o_rx_dv.
